// File: rtl/nano_intc_pkg.sv
// Shared constants, register offsets and helpers for the nano interrupt controller.
package nano_intc_pkg;

    localparam int NSRC = 8;
    localparam logic [3:0] IDLE_DS = 4'hF;

    typedef enum logic [1:0] {
        OFF_PEND = 2'd0,
        OFF_MASK = 2'd1,
        OFF_INS  = 2'd2,
        OFF_STAT = 2'd3
    } reg_off_e;

    function automatic logic [NSRC-1:0] onehot(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

    function automatic logic [7:0] vec_of(input logic [7:0] base, input int unsigned shift,
                                          input logic [2:0] idx);
        return base + 8'({5'd0, idx} << shift);
    endfunction

endpackage

// File: rtl/nano_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 wins.
module nano_prio_enc
    import nano_intc_pkg::*;
(
    input  logic [NSRC-1:0] i_req,
    output logic            o_valid,
    output logic [2:0]      o_idx
);

    // NOTE: every output gets a default first, so no path through the block infers a latch.
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = 3'(i);
        end
    end

endmodule

// File: rtl/nano_intc.sv
// Eight-source priority interrupt controller: pending/mask/in-service tracking,
// vector supply during INT_ACK and a four-register I/O-bus programming interface.
module nano_intc
    import nano_intc_pkg::*;
#(
    parameter logic [3:0]  DEV_BASE     = 4'h8,
    parameter logic [7:0]  EDGE_MASK    = 8'h00,
    parameter logic [7:0]  VEC_BASE     = 8'h40,
    parameter int unsigned VEC_SHIFT    = 3,
    parameter logic [7:0]  VEC_SPURIOUS = 8'hFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_in,
    input  logic [3:0]      ds,
    input  logic            rw,
    input  logic [7:0]      wdata,
    output logic [7:0]      rdata,
    output logic            rdata_oe,
    output logic            int_req,
    input  logic            int_ack
);

    logic [NSRC-1:0] r_s1, r_s2, r_s3;
    logic [NSRC-1:0] r_pend, r_mask, r_ins;
    logic [2:0]      r_idx_q;
    logic            r_int_req;

    logic            w_acc, w_wr, w_rd;
    reg_off_e        w_off;
    logic            w_ins_v, w_elig_v;
    logic [2:0]      w_ins_idx, w_elig_idx;
    logic [NSRC-1:0] w_allow, w_elig;
    logic [NSRC-1:0] w_ack_bit, w_eoi_clr, w_w1c, w_edge_set, w_pend_nxt;

    assign w_acc = (ds[3:2] == DEV_BASE[3:2]);
    assign w_off = reg_off_e'(ds[1:0] - DEV_BASE[1:0]);
    assign w_wr  = w_acc & rw;
    assign w_rd  = w_acc & ~rw;

    nano_prio_enc u_ins_enc (
        .i_req   (r_ins),
        .o_valid (w_ins_v),
        .o_idx   (w_ins_idx)
    );

    // Only sources strictly above the highest-priority in-service bit may nest.
    assign w_allow = w_ins_v ? (onehot(w_ins_idx) - 8'd1) : '1;
    assign w_elig  = r_pend & r_mask & ~r_ins & w_allow;

    nano_prio_enc u_elig_enc (
        .i_req   (w_elig),
        .o_valid (w_elig_v),
        .o_idx   (w_elig_idx)
    );

    assign w_ack_bit  = (int_ack && r_int_req) ? onehot(r_idx_q) : '0;
    assign w_eoi_clr  = (w_wr && w_off == OFF_INS && w_ins_v) ? onehot(w_ins_idx) : '0;
    assign w_w1c      = (w_wr && w_off == OFF_PEND) ? (wdata & EDGE_MASK) : '0;
    assign w_edge_set = r_s2 & ~r_s3 & EDGE_MASK;
    // A fresh edge beats a clear arriving in the same clock.
    assign w_pend_nxt = (((r_pend & ~w_w1c & ~w_ack_bit) | w_edge_set) & EDGE_MASK)
                      | (r_s2 & ~EDGE_MASK);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_s3      <= '0;
            r_pend    <= '0;
            r_mask    <= '0;
            r_ins     <= '0;
            r_idx_q   <= '0;
            r_int_req <= 1'b0;
        end else begin
            r_s1      <= irq_in;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_pend    <= w_pend_nxt;
            if (w_wr && w_off == OFF_MASK) r_mask <= wdata;
            r_ins     <= (r_ins & ~w_eoi_clr) | w_ack_bit;
            r_idx_q   <= w_elig_idx;
            r_int_req <= w_elig_v;
        end
    end

    // The ack owns the data bus; reset releases it immediately.
    always_comb begin
        rdata    = '0;
        rdata_oe = 1'b0;
        if (!rst) begin
            if (int_ack) begin
                rdata_oe = 1'b1;
                rdata    = r_int_req ? vec_of(VEC_BASE, VEC_SHIFT, r_idx_q) : VEC_SPURIOUS;
            end else if (w_rd) begin
                rdata_oe = 1'b1;
                case (w_off)
                    OFF_PEND: rdata = r_pend;
                    OFF_MASK: rdata = r_mask;
                    OFF_INS:  rdata = r_ins;
                    default:  rdata = {r_int_req, 4'b0000, r_idx_q};
                endcase
            end
        end
    end

    assign int_req = r_int_req;

endmodule

// File: tb/tb_nano_intc.sv
// Self-checking bench for nano_intc: register-map vector table plus interrupt sequences.
module tb_nano_intc;
    import nano_intc_pkg::*;

    localparam logic [3:0] DEV   = 4'h8;
    localparam logic [7:0] EDGES = 8'h7E;

    logic            clk, rst, rw, rdata_oe, int_req, int_ack;
    logic [NSRC-1:0] irq_in;
    logic [3:0]      ds;
    logic [7:0]      wdata, rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    string      q_name[$];
    logic [8:0] q_exp[$];

    typedef struct {
        logic [3:0] ds;
        logic       rw;
        logic [7:0] wd;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[14];

    nano_intc #(
        .DEV_BASE  (DEV),
        .EDGE_MASK (EDGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .ds       (ds),
        .rw       (rw),
        .wdata    (wdata),
        .rdata    (rdata),
        .rdata_oe (rdata_oe),
        .int_req  (int_req),
        .int_ack  (int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_req(input string name, input logic exp);
        check(name, {8'h00, int_req}, {8'h00, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expectation and compare it with the bus mid-cycle.
    task automatic drain();
        string      n;
        logic [8:0] e;
        @(negedge clk);
        n = q_name.pop_front();
        e = q_exp.pop_front();
        check(n, {rdata_oe, rdata}, e);
    endtask

    task automatic bus(input logic [3:0] d, input logic w, input logic [7:0] wd,
                       input logic [8:0] exp, input string name);
        ds    = d;
        rw    = w;
        wdata = wd;
        q_name.push_back(name);
        q_exp.push_back(exp);
        drain();
        tick();
        ds    = IDLE_DS;
        rw    = 1'b0;
        wdata = '0;
    endtask

    task automatic rd(input reg_off_e off, input logic [7:0] exp, input string name);
        bus(DEV + 4'(off), 1'b0, 8'h00, {1'b1, exp}, name);
    endtask

    task automatic wr(input reg_off_e off, input logic [7:0] data, input string name);
        bus(DEV + 4'(off), 1'b1, data, 9'h000, name);
    endtask

    task automatic ack(input logic [7:0] exp, input string name);
        int_ack = 1'b1;
        q_name.push_back(name);
        q_exp.push_back({1'b1, exp});
        drain();
        tick();
        int_ack = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        irq_in  = '0;
        ds      = IDLE_DS;
        rw      = 1'b0;
        wdata   = '0;
        int_ack = 1'b0;

        tbl[0]  = '{DEV + 4'd0, 1'b0, 8'h00, 9'h100};
        tbl[1]  = '{DEV + 4'd1, 1'b0, 8'h00, 9'h100};
        tbl[2]  = '{DEV + 4'd2, 1'b0, 8'h00, 9'h100};
        tbl[3]  = '{DEV + 4'd3, 1'b0, 8'h00, 9'h100};
        tbl[4]  = '{DEV + 4'd1, 1'b1, 8'hA5, 9'h000};
        tbl[5]  = '{DEV + 4'd1, 1'b0, 8'h00, 9'h1A5};
        tbl[6]  = '{DEV + 4'd3, 1'b1, 8'hFF, 9'h000};
        tbl[7]  = '{DEV + 4'd3, 1'b0, 8'h00, 9'h100};
        tbl[8]  = '{DEV + 4'd2, 1'b1, 8'hFF, 9'h000};
        tbl[9]  = '{DEV + 4'd2, 1'b0, 8'h00, 9'h100};
        tbl[10] = '{IDLE_DS,    1'b0, 8'h00, 9'h000};
        tbl[11] = '{4'h4,       1'b0, 8'h00, 9'h000};
        tbl[12] = '{DEV + 4'd1, 1'b1, 8'hFF, 9'h000};
        tbl[13] = '{DEV + 4'd1, 1'b0, 8'h00, 9'h1FF};

        #2;
        check_req("reset_int_req", 1'b0);
        check("reset_bus", {rdata_oe, rdata}, 9'h000);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            bus(tbl[i].ds, tbl[i].rw, tbl[i].wd, tbl[i].exp, $sformatf("tbl[%0d]", i));
        end

        // Edge source 3: request latency, vector, in-service and pending after ack.
        irq_in = 8'h08;
        tick();
        tick();
        irq_in = 8'h00;
        tick();
        check_req("s3_req_e3", 1'b0);
        tick();
        check_req("s3_req_e4", 1'b1);
        rd(OFF_STAT, 8'h83, "s3_stat");
        ack(8'h58, "s3_vec");
        rd(OFF_INS, 8'h08, "s3_ins");
        check_req("s3_req_drop", 1'b0);
        rd(OFF_PEND, 8'h00, "s3_pend");
        wr(OFF_INS, 8'h00, "s3_eoi");
        rd(OFF_INS, 8'h00, "s3_ins_clr");

        // Sources 5 and 2 together: 2 first, 5 held off until EOI.
        irq_in = 8'h24;
        repeat (4) tick();
        check_req("p25_req", 1'b1);
        rd(OFF_STAT, 8'h82, "p25_stat2");
        ack(8'h50, "p25_vec2");
        tick();
        check_req("p25_blocked", 1'b0);
        rd(OFF_PEND, 8'h20, "p25_pend");
        wr(OFF_INS, 8'h00, "p25_eoi2");
        tick();
        check_req("p25_req5", 1'b1);
        rd(OFF_STAT, 8'h85, "p25_stat5");
        ack(8'h68, "p25_vec5");
        wr(OFF_INS, 8'h00, "p25_eoi5");
        irq_in = 8'h00;
        rd(OFF_INS, 8'h00, "p25_ins_clr");

        // Nesting: 6 blocked under in-service 4, 1 nests.
        irq_in = 8'h10;
        repeat (4) tick();
        check_req("n_req4", 1'b1);
        ack(8'h60, "n_vec4");
        irq_in = 8'h40;
        repeat (5) tick();
        check_req("n_req6_blocked", 1'b0);
        rd(OFF_PEND, 8'h40, "n_pend6");
        irq_in = 8'h42;
        repeat (4) tick();
        check_req("n_req1", 1'b1);
        rd(OFF_STAT, 8'h81, "n_stat1");
        ack(8'h48, "n_vec1");
        rd(OFF_INS, 8'h12, "n_ins_nested");
        wr(OFF_INS, 8'h00, "n_eoi1");
        rd(OFF_INS, 8'h10, "n_ins_after_eoi1");
        check_req("n_req6_still_blocked", 1'b0);
        wr(OFF_INS, 8'h00, "n_eoi4");
        tick();
        check_req("n_req6", 1'b1);
        rd(OFF_STAT, 8'h86, "n_stat6");
        ack(8'h70, "n_vec6");
        wr(OFF_INS, 8'h00, "n_eoi6");
        irq_in = 8'h00;
        rd(OFF_INS, 8'h00, "n_ins_clr");

        // Level source 0 held high through its EOI.
        irq_in = 8'h01;
        repeat (4) tick();
        check_req("l_req", 1'b1);
        ack(8'h40, "l_vec");
        rd(OFF_PEND, 8'h01, "l_pend_kept");
        check_req("l_req_drop", 1'b0);
        wr(OFF_INS, 8'h00, "l_eoi");
        check_req("l_req_eoi_edge", 1'b0);
        tick();
        check_req("l_req_reassert", 1'b1);
        ack(8'h40, "l_vec2");
        irq_in = 8'h00;
        wr(OFF_INS, 8'h00, "l_eoi2");
        repeat (4) tick();
        check_req("l_req_idle", 1'b0);
        rd(OFF_PEND, 8'h00, "l_pend_idle");

        // Mask removed before the ack: spurious vector, no state change.
        irq_in = 8'h04;
        repeat (4) tick();
        check_req("sp_req", 1'b1);
        irq_in = 8'h00;
        wr(OFF_MASK, 8'h00, "sp_mask0");
        tick();
        check_req("sp_req_drop", 1'b0);
        ack(8'hFF, "sp_vec");
        rd(OFF_INS, 8'h00, "sp_ins");
        rd(OFF_PEND, 8'h04, "sp_pend_kept");
        wr(OFF_PEND, 8'h04, "sp_w1c");
        rd(OFF_PEND, 8'h00, "sp_pend_clr");
        wr(OFF_MASK, 8'hFF, "sp_mask_ff");

        // Reset asserted in the middle of an ack clock.
        irq_in = 8'h08;
        repeat (4) tick();
        check_req("ra_req", 1'b1);
        int_ack = 1'b1;
        #1;
        check("ra_vec", {rdata_oe, rdata}, 9'h158);
        rst    = 1'b1;
        irq_in = 8'h00;
        #1;
        check_req("ra_req_rst", 1'b0);
        check("ra_bus_rst", {rdata_oe, rdata}, 9'h000);
        tick();
        int_ack = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rd(OFF_INS, 8'h00, "ra_ins");
        rd(OFF_MASK, 8'h00, "ra_mask");
        rd(OFF_PEND, 8'h00, "ra_pend");
        check_req("ra_req_after", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
